// File: rtl/audio_frame_buffer_if.sv
// Sample capture and frame streaming signals of the audio frame buffer.
// The design attaches through slave; the producer/consumer side uses master.
interface audio_frame_buffer_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int CNT_W      = 8
);
  logic                  ready;
  logic [WIDTH-1:0]      audio_in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [DEPTH_LOG2-1:0] out_index;
  logic                  out_last;
  logic [CNT_W-1:0]      overrun_count;
  logic [CNT_W-1:0]      frame_count;

  modport slave (
    input  ready, audio_in_data, out_ready,
    output out_valid, out_data, out_index, out_last,
    output overrun_count, frame_count
  );

  modport master (
    output ready, audio_in_data, out_ready,
    input  out_valid, out_data, out_index, out_last,
    input  overrun_count, frame_count
  );
endinterface

// File: rtl/audio_frame_buffer.sv
// Ping-pong frame capture of AC97 samples with valid/ready frame streaming.
// Frames completing while the spare bank is still busy are dropped.
module audio_frame_buffer #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int CNT_W      = 8
) (
  input logic                  clock_27mhz,
  input logic                  reset_b,
  audio_frame_buffer_if.slave  bus
);
  localparam int N = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST = DEPTH_LOG2'(N - 1);
  localparam logic [DEPTH_LOG2-1:0] ONE  = DEPTH_LOG2'(1);
  localparam logic [CNT_W-1:0]      CONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } st_e;

  st_e st_q, st_d;

  logic [WIDTH-1:0] mem_q [2*N];
  logic [WIDTH-1:0] rdata_q;

  logic [DEPTH_LOG2-1:0] widx_q, widx_d;
  logic [DEPTH_LOG2-1:0] ridx_q, ridx_d;
  logic [DEPTH_LOG2-1:0] raddr;
  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  logic [1:0]            pend_q, pend_d;
  logic                  reading_q, reading_d;
  logic [CNT_W-1:0]      ovr_q, ovr_d;
  logic [CNT_W-1:0]      frm_q, frm_d;

  logic fire, rel, claim, rd_en;
  logic done, other_free, swap;

  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) st_q <= IDLE;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (|pend_q) st_d = FETCH;
      FETCH:   st_d = STREAM;
      STREAM:  if (rel) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid     = (st_q == STREAM);
    bus.out_last      = bus.out_valid & (ridx_q == LAST);
    bus.out_data      = rdata_q;
    bus.out_index     = ridx_q;
    bus.overrun_count = ovr_q;
    bus.frame_count   = frm_q;
    fire  = bus.out_valid & bus.out_ready;
    rel   = fire & bus.out_last;
    claim = (st_q == IDLE) & (|pend_q);
    rd_en = (st_q == FETCH) | (fire & ~rel);
    raddr = (st_q == FETCH) ? '0 : ridx_q + ONE;
  end

  // A release in the completion cycle frees the spare bank in time to swap
  always_comb begin
    done       = bus.ready & (widx_q == LAST);
    other_free = ~pend_q[~wbank_q]
               & ~(reading_q & (rbank_q != wbank_q) & ~rel);
    swap       = done & other_free;
    widx_d     = bus.ready ? widx_q + ONE : widx_q;
    wbank_d    = wbank_q ^ swap;
    rbank_d    = claim ? pend_q[1] : rbank_q;
    pend_d     = pend_q;
    if (claim) pend_d[rbank_d] = 1'b0;
    if (swap)  pend_d[wbank_q] = 1'b1;
    reading_d  = claim ? 1'b1 : (rel ? 1'b0 : reading_q);
    ridx_d     = rd_en ? raddr : ridx_q;
    ovr_d      = ovr_q;
    if (done & ~other_free & ~(&ovr_q)) ovr_d = ovr_q + CONE;
    frm_d      = rel ? frm_q + CONE : frm_q;
  end

  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      widx_q    <= '0;
      ridx_q    <= '0;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      pend_q    <= '0;
      reading_q <= 1'b0;
      ovr_q     <= '0;
      frm_q     <= '0;
      rdata_q   <= '0;
    end else begin
      widx_q    <= widx_d;
      ridx_q    <= ridx_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      pend_q    <= pend_d;
      reading_q <= reading_d;
      ovr_q     <= ovr_d;
      frm_q     <= frm_d;
      if (rd_en) rdata_q <= mem_q[{rbank_q, raddr}];
    end
  end

  always_ff @(posedge clock_27mhz) begin
    if (bus.ready) mem_q[{wbank_q, widx_q}] <= bus.audio_in_data;
  end
endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer with 16-sample frames.
// Inputs change 1ns after posedge; outputs are sampled at the same point.
module tb_audio_frame_buffer;
  logic clk;
  logic rst_n;
  int   n_asrt;
  int   n_fail;

  audio_frame_buffer_if #(
    .WIDTH(16), .DEPTH_LOG2(4), .CNT_W(8)
  ) bus ();

  audio_frame_buffer #(
    .WIDTH(16), .DEPTH_LOG2(4), .CNT_W(8)
  ) dut (
    .clock_27mhz(clk),
    .reset_b(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int d);
    bus.ready = 1'b1;
    bus.audio_in_data = 16'(d);
    tick();
    bus.ready = 1'b0;
  endtask

  task automatic feed(input int base, input int gap);
    for (int i = 0; i < 16; i++) begin
      repeat (gap - 1) tick();
      strobe(base + i);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic stream(input int base, input string tag);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_data"}, 32'(bus.out_data), 32'(base + k));
      chk({tag, "_index"}, 32'(bus.out_index), 32'(k));
      chk({tag, "_last"}, 32'(bus.out_last), 32'(k == 15));
      tick();
    end
    chk({tag, "_end_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] pat;
    int k;
    int c;
    n_asrt = 0;
    n_fail = 0;
    pat = 4'b1001;
    rst_n = 1'b0;
    bus.ready = 1'b0;
    bus.audio_in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_index", 32'(bus.out_index), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_ovr", 32'(bus.overrun_count), 32'd0);
    chk("rst_frm", 32'(bus.frame_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: nominal spacing, continuous acceptance, two-cycle latency
    bus.out_ready = 1'b1;
    feed(0, 562);
    chk("t1_lat0", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t1_lat1", 32'(bus.out_valid), 32'd0);
    tick();
    stream(0, "t1");
    chk("t1_frm", 32'(bus.frame_count), 32'd1);
    chk("t1_ovr", 32'(bus.overrun_count), 32'd0);

    // 2: 1,0,0,1 acceptance pattern
    do_reset();
    bus.out_ready = 1'b0;
    feed(0, 562);
    wait_valid("t2_start");
    k = 0;
    c = 0;
    while (k < 16 && c < 200) begin
      bus.out_ready = pat[c % 4];
      chk("t2_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_data", 32'(bus.out_data), 32'(k));
      chk("t2_index", 32'(bus.out_index), 32'(k));
      chk("t2_last", 32'(bus.out_last), 32'(k == 15));
      if (bus.out_ready) k++;
      tick();
      c++;
    end
    chk("t2_beats", 32'(k), 32'd16);
    chk("t2_end_valid", 32'(bus.out_valid), 32'd0);
    chk("t2_frm", 32'(bus.frame_count), 32'd1);

    // 3: overruns while the reader is stalled
    do_reset();
    bus.out_ready = 1'b0;
    feed(0, 2);
    feed(100, 2);
    feed(200, 2);
    tick();
    chk("t3_ovr", 32'(bus.overrun_count), 32'd2);
    chk("t3_hold_data", 32'(bus.out_data), 32'd0);
    bus.out_ready = 1'b1;
    stream(0, "t3a");
    chk("t3_frm1", 32'(bus.frame_count), 32'd1);
    feed(300, 2);
    wait_valid("t3_start_d");
    stream(300, "t3d");
    chk("t3_frm2", 32'(bus.frame_count), 32'd2);
    chk("t3_ovr_end", 32'(bus.overrun_count), 32'd2);

    // 4: last-beat release coincides with the final strobe
    do_reset();
    bus.out_ready = 1'b0;
    feed(0, 2);
    for (int i = 0; i < 15; i++) begin
      repeat (1) tick();
      strobe(500 + i);
    end
    tick();
    chk("t4_stalled", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    for (int b = 0; b < 15; b++) begin
      chk("t4_data", 32'(bus.out_data), 32'(b));
      tick();
    end
    chk("t4_lastbeat", 32'(bus.out_last), 32'd1);
    strobe(515);
    chk("t4_ovr", 32'(bus.overrun_count), 32'd0);
    chk("t4_frm1", 32'(bus.frame_count), 32'd1);
    chk("t4_gap", 32'(bus.out_valid), 32'd0);
    wait_valid("t4_start2");
    stream(500, "t4b");
    chk("t4_frm2", 32'(bus.frame_count), 32'd2);
    chk("t4_ovr_end", 32'(bus.overrun_count), 32'd0);

    // 5: asynchronous reset at beat 7
    do_reset();
    bus.out_ready = 1'b1;
    feed(40, 2);
    wait_valid("t5_start");
    for (int b = 0; b < 7; b++) tick();
    chk("t5_beat7", 32'(bus.out_index), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_async_data", 32'(bus.out_data), 32'd0);
    chk("t5_async_index", 32'(bus.out_index), 32'd0);
    chk("t5_async_frm", 32'(bus.frame_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    feed(1000, 2);
    wait_valid("t5_start2");
    stream(1000, "t5b");
    chk("t5_frm", 32'(bus.frame_count), 32'd1);

    // 6: overrun counter saturation
    do_reset();
    bus.out_ready = 1'b0;
    for (int f = 0; f < 256; f++) feed(f, 2);
    tick();
    chk("t6_ovr255", 32'(bus.overrun_count), 32'd255);
    for (int f = 0; f < 5; f++) feed(f, 2);
    tick();
    chk("t6_ovr_sat", 32'(bus.overrun_count), 32'd255);
    chk("t6_frm", 32'(bus.frame_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end
endmodule
